alu_ctrl_seq: RTL and testbench
===============================

// Module: alu_ctrl_seq
// PURPOSE
//   Registered, handshaked successor to the combinational ALU control decoder.
//   Decodes ALUop/funct3/funct7 into a 5-bit ALU operation code covering RV32I
//   and, optionally, RV32M. Sequences multi-cycle MUL/DIV ops with a latency
//   counter. Sits between decode and execute in the multi-cycle datapath.
// PARAMETERS
//   ENABLE_M  1   1: decode RV32M (funct7=0000001); 0: those encodings are illegal
//   MUL_LAT   2   extra execute cycles for MUL/MULH/MULHSU/MULHU (>=1)
//   DIV_LAT   33  extra execute cycles for DIV/DIVU/REM/REMU (>=1)
// PORTS
//   clk          in   1  rising-edge clock
//   rst          in   1  synchronous reset, active-high
//   flush        in   1  synchronous abort of any held/in-flight op
//   in_valid     in   1  decode stage presents an op
//   in_ready     out  1  op accepted on edge where in_valid&in_ready
//   ALUop        in   2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
//   funct3       in   3  instr[14:12]
//   funct7       in   7  instr[31:25]
//   out_valid    out  1  ALUctrl/illegal/multi_cycle valid for execute
//   out_ready    in   1  execute consumes on edge where out_valid&out_ready
//   ALUctrl      out  5  operation code (table below)
//   multi_cycle  out  1  registered op is MUL/DIV class
//   illegal      out  1  registered op was an illegal encoding
//   busy         out  1  high in state WAIT
// BEHAVIOUR
//   Codes: ADD 00 SUB 01 SLL 02 SLT 03 SLTU 04 XOR 05 SRL 06 SRA 07 OR 08 AND 09
//     MUL 10 MULH 11 MULHSU 12 MULHU 13 DIV 14 DIVU 15 REM 16 REMU 17 (hex).
//   ALUop 00 -> ADD. ALUop 01: f3 000/001 -> SUB, 100/101 -> SLT, 110/111 -> SLTU,
//     010/011 illegal.
//   ALUop 10: f7=00 std map; f7=20 with f3=000 -> SUB, 101 -> SRA;
//     f7=01 (ENABLE_M) -> M map by f3. Any other f7/f3 combination is illegal.
//   ALUop 11: f3 map, no SUB. f3=001 needs f7=00; f3=101 f7=00 SRL, 20 SRA.
//     Other shift f7 is illegal.
//   Illegal op: ALUctrl=ADD, illegal=1, multi_cycle=0, single-cycle path.
//   FSM IDLE/WAIT/OUT. in_ready = !flush & (IDLE | (OUT & out_ready)).
//   IDLE->OUT on accept of a single-cycle op. Output registered, out_valid high
//     the cycle after accept (latency 1).
//   IDLE->WAIT on accept of an M op. Counter loads MUL_LAT or DIV_LAT.
//     out_valid rises exactly LAT cycles later than a single-cycle op would.
//   WAIT->OUT when counter reaches terminal. ALUctrl is already valid but is
//     not presented.
//   OUT: ALUctrl/illegal/multi_cycle held stable while out_valid & !out_ready.
//     On out_ready: new accept in the same cycle -> OUT/WAIT per the new op
//     (back-to-back, no bubble). Otherwise -> IDLE.
//   flush: next state IDLE, out_valid 0, counter cleared. A same-cycle in_valid
//     is not accepted. Output regs keep their values.
//   rst overrides flush and all inputs.
//   Reset values: state IDLE, out_valid 0, ALUctrl 00, illegal 0,
//     multi_cycle 0, busy 0, counter 0.
//   Inputs sampled only on the accept edge. Changes while not accepted are ignored.
// TESTING
//   Reset, ALUop=10 f3=000 f7=20 valid 1 cycle, out_ready=1 -> next cycle
//     out_valid=1, ALUctrl=01, then IDLE.
//   ALUop=10 f3=100 f7=01, MUL_LAT=2 DIV_LAT=33 -> busy for the DIV window,
//     out_valid 34 cycles after accept, ALUctrl=14, multi_cycle=1.
//   Stream of 4 ALU ops, out_ready=1 -> one out_valid per cycle, no bubbles.
//     Stall out_ready 3 cycles -> ALUctrl stable, in_ready=0.
//   Illegal: ALUop=10 f7=20 f3=111, and ENABLE_M=0 with f7=01 -> illegal=1,
//     ALUctrl=00, latency 1.
//   flush in WAIT mid-divide, and flush with in_valid=1 -> out_valid never
//     rises, in_ready=0 that cycle, IDLE next.
//   rst asserted in OUT with out_ready=0 -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control decoder for the multi-cycle datapath.
// Decodes ALUop/funct3/funct7 into a 5-bit op code and holds MUL/DIV ops for their execute latency.
module alu_ctrl_seq #(
    parameter int ENABLE_M = 1,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] ALUop,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] ALUctrl,
    output logic       multi_cycle,
    output logic       illegal,
    output logic       busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_SLL  = 5'h02;
    localparam logic [4:0] OP_SLT  = 5'h03;
    localparam logic [4:0] OP_SLTU = 5'h04;
    localparam logic [4:0] OP_XOR  = 5'h05;
    localparam logic [4:0] OP_SRL  = 5'h06;
    localparam logic [4:0] OP_SRA  = 5'h07;
    localparam logic [4:0] OP_OR   = 5'h08;
    localparam logic [4:0] OP_AND  = 5'h09;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [6:0] F7_MEXT = 7'h01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_OUT
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    code_q, code_d;
    logic          ill_q, ill_d;
    logic          mc_q, mc_d;

    logic [4:0]    decCode;
    logic          decIll;
    logic          decMulti;
    logic          accept;

    function automatic logic [4:0] stdMap(input logic [2:0] f3);
        logic [4:0] code;
        case (f3)
            3'b000:  code = OP_ADD;
            3'b001:  code = OP_SLL;
            3'b010:  code = OP_SLT;
            3'b011:  code = OP_SLTU;
            3'b100:  code = OP_XOR;
            3'b101:  code = OP_SRL;
            3'b110:  code = OP_OR;
            default: code = OP_AND;
        endcase
        return code;
    endfunction

    // M-extension codes are 0x10 + funct3, so bit 4 marks multi-cycle and bit 2 marks the divide class.
    always_comb begin
        decCode = OP_ADD;
        decIll  = 1'b0;
        case (ALUop)
            2'b01: begin
                case (funct3)
                    3'b000, 3'b001: decCode = OP_SUB;
                    3'b100, 3'b101: decCode = OP_SLT;
                    3'b110, 3'b111: decCode = OP_SLTU;
                    default:        decIll  = 1'b1;
                endcase
            end
            2'b10: begin
                if (funct7 == F7_BASE) begin
                    decCode = stdMap(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    decCode = OP_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    decCode = OP_SRA;
                end else if (funct7 == F7_MEXT && ENABLE_M != 0) begin
                    decCode = {2'b10, funct3};
                end else begin
                    decIll = 1'b1;
                end
            end
            2'b11: begin
                decCode = stdMap(funct3);
                if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    decIll = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT) begin
                        decCode = OP_SRA;
                    end else if (funct7 != F7_BASE) begin
                        decIll = 1'b1;
                    end
                end
            end
            default: decCode = OP_ADD;
        endcase
        if (decIll) begin
            decCode = OP_ADD;
        end
        decMulti = !decIll && decCode[4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= OP_ADD;
            ill_q   <= 1'b0;
            mc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            ill_q   <= ill_d;
            mc_q    <= mc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        ill_d   = ill_q;
        mc_d    = mc_q;
        accept  = in_valid && in_ready;

        case (state_q)
            S_WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = S_OUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        // An accept in OUT overrides the return to IDLE, giving back-to-back issue.
        if (accept) begin
            code_d = decCode;
            ill_d  = decIll;
            mc_d   = decMulti;
            if (decMulti) begin
                state_d = S_WAIT;
                cnt_d   = decCode[2] ? DIV_CNT : MUL_CNT;
            end else begin
                state_d = S_OUT;
                cnt_d   = '0;
            end
        end

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        in_ready    = !flush && (state_q == S_IDLE || (state_q == S_OUT && out_ready));
        out_valid   = (state_q == S_OUT);
        busy        = (state_q == S_WAIT);
        ALUctrl     = code_q;
        illegal     = ill_q;
        multi_cycle = mc_q;
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed scoreboard bench for alu_ctrl_seq; a second instance with the M extension
// disabled checks that RV32M encodings decode as illegal.
module tb_alu_ctrl_seq;

    typedef struct packed {
        logic [4:0] code;
        logic       ill;
        logic       mc;
    } sbEntry_t;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       inValid;
    logic       inReady;
    logic [1:0] aluOp;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       outValid;
    logic       outReady;
    logic [4:0] aluCtrl;
    logic       multiCycle;
    logic       illegal;
    logic       busy;

    logic       nomInReady;
    logic       nomOutValid;
    logic [4:0] nomAluCtrl;
    logic       nomMultiCycle;
    logic       nomIllegal;
    logic       nomBusy;

    sbEntry_t   sb[$];
    int         passCount  = 0;
    int         totalCount = 0;

    alu_ctrl_seq #(.ENABLE_M(1), .MUL_LAT(2), .DIV_LAT(33)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReady),
        .ALUop(aluOp), .funct3(funct3), .funct7(funct7), .out_valid(outValid),
        .out_ready(outReady), .ALUctrl(aluCtrl), .multi_cycle(multiCycle),
        .illegal(illegal), .busy(busy)
    );

    alu_ctrl_seq #(.ENABLE_M(0), .MUL_LAT(2), .DIV_LAT(33)) dutNoM (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(nomInReady),
        .ALUop(aluOp), .funct3(funct3), .funct7(funct7), .out_valid(nomOutValid),
        .out_ready(outReady), .ALUctrl(nomAluCtrl), .multi_cycle(nomMultiCycle),
        .illegal(nomIllegal), .busy(nomBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before 200000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Drives one cycle of inputs, checks handshake/status and the head of the scoreboard,
    // then retires/pushes entries the way the handshake says it should.
    task automatic applyStimulus(input string tag, input logic v, input logic [1:0] op,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] expCode, input logic expIll, input logic expMc,
                                 input logic ordy, input logic flsh, input logic expRdy,
                                 input logic expOv, input logic expBusy);
        sbEntry_t head;
        sbEntry_t entry;
        inValid  = v;
        aluOp    = op;
        funct3   = f3;
        funct7   = f7;
        outReady = ordy;
        flush    = flsh;
        #1;
        checkOutput({tag, ".in_ready"}, 5'(inReady), 5'(expRdy));
        checkOutput({tag, ".out_valid"}, 5'(outValid), 5'(expOv));
        checkOutput({tag, ".busy"}, 5'(busy), 5'(expBusy));
        if (expOv) begin
            if (sb.size() == 0) begin
                totalCount++;
                $error("[TB] FAIL %s.sb: observed no pending entry, required one", tag);
            end else begin
                head = sb[0];
                checkOutput({tag, ".ALUctrl"}, aluCtrl, head.code);
                checkOutput({tag, ".illegal"}, 5'(illegal), 5'(head.ill));
                checkOutput({tag, ".multi_cycle"}, 5'(multiCycle), 5'(head.mc));
            end
        end
        if (flsh) begin
            sb.delete();
        end else if (expOv && ordy && sb.size() > 0) begin
            void'(sb.pop_front());
        end
        if (v && expRdy) begin
            entry.code = expCode;
            entry.ill  = expIll;
            entry.mc   = expMc;
            sb.push_back(entry);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleStep(input string tag, input logic ordy, input logic expRdy,
                            input logic expOv, input logic expBusy);
        applyStimulus(tag, 1'b0, 2'b00, 3'b000, 7'h00, 5'h00, 1'b0, 1'b0,
                      ordy, 1'b0, expRdy, expOv, expBusy);
    endtask

    task automatic checkNoM(input string tag);
        checkOutput({tag, ".nom_out_valid"}, 5'(nomOutValid), 5'(1'b1));
        checkOutput({tag, ".nom_illegal"}, 5'(nomIllegal), 5'(1'b1));
        checkOutput({tag, ".nom_ALUctrl"}, nomAluCtrl, 5'h00);
        checkOutput({tag, ".nom_multi_cycle"}, 5'(nomMultiCycle), 5'(1'b0));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".out_valid"}, 5'(outValid), 5'(1'b0));
        checkOutput({tag, ".ALUctrl"}, aluCtrl, 5'h00);
        checkOutput({tag, ".illegal"}, 5'(illegal), 5'(1'b0));
        checkOutput({tag, ".multi_cycle"}, 5'(multiCycle), 5'(1'b0));
        checkOutput({tag, ".busy"}, 5'(busy), 5'(1'b0));
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        inValid  = 1'b0;
        aluOp    = 2'b00;
        funct3   = 3'b000;
        funct7   = 7'h00;
        outReady = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetValues("reset");

        // SUB, latency 1, then back to IDLE
        applyStimulus("sub", 1'b1, 2'b10, 3'b000, 7'h20, 5'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idleStep("sub_out", 1'b1, 1'b1, 1'b1, 1'b0);
        idleStep("sub_idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // DIV holds for 33 extra cycles
        applyStimulus("div", 1'b1, 2'b10, 3'b100, 7'h01, 5'h14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkNoM("div");
        for (int k = 0; k < 33; k++) begin
            idleStep($sformatf("div_wait%0d", k), 1'b1, 1'b0, 1'b0, 1'b1);
        end
        idleStep("div_out", 1'b1, 1'b1, 1'b1, 1'b0);
        idleStep("div_idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // MUL holds for 2 extra cycles
        applyStimulus("mul", 1'b1, 2'b10, 3'b000, 7'h01, 5'h10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkNoM("mul");
        idleStep("mul_wait0", 1'b1, 1'b0, 1'b0, 1'b1);
        idleStep("mul_wait1", 1'b1, 1'b0, 1'b0, 1'b1);
        idleStep("mul_out", 1'b1, 1'b1, 1'b1, 1'b0);

        // back-to-back stream
        applyStimulus("s_add", 1'b1, 2'b10, 3'b000, 7'h00, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("s_xori", 1'b1, 2'b11, 3'b100, 7'h00, 5'h05, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus("s_sll", 1'b1, 2'b10, 3'b001, 7'h00, 5'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus("s_bltu", 1'b1, 2'b01, 3'b110, 7'h00, 5'h04, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idleStep("s_last", 1'b1, 1'b1, 1'b1, 1'b0);
        idleStep("s_idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // stall: held op stays stable, new op is ignored
        applyStimulus("st_andi", 1'b1, 2'b11, 3'b111, 7'h55, 5'h09, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus($sformatf("st_hold%0d", k), 1'b1, 2'b10, 3'b000, 7'h20, 5'h01, 1'b0, 1'b0,
                          1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        idleStep("st_release", 1'b1, 1'b1, 1'b1, 1'b0);
        idleStep("st_idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // illegal encodings
        applyStimulus("ill_r", 1'b1, 2'b10, 3'b111, 7'h20, 5'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus("ill_shi", 1'b1, 2'b11, 3'b101, 7'h10, 5'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus("ill_br", 1'b1, 2'b01, 3'b010, 7'h00, 5'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus("srai", 1'b1, 2'b11, 3'b101, 7'h20, 5'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idleStep("srai_out", 1'b1, 1'b1, 1'b1, 1'b0);
        idleStep("ill_idle", 1'b1, 1'b1, 1'b0, 1'b0);

        // flush mid-divide with a competing in_valid
        applyStimulus("fl_divu", 1'b1, 2'b10, 3'b101, 7'h01, 5'h15, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            idleStep($sformatf("fl_wait%0d", k), 1'b1, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus("fl_wait", 1'b1, 2'b10, 3'b000, 7'h00, 5'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 36; k++) begin
            idleStep($sformatf("fl_quiet%0d", k), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        applyStimulus("fl_idle", 1'b1, 2'b10, 3'b000, 7'h00, 5'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idleStep("fl_after", 1'b1, 1'b1, 1'b0, 1'b0);

        // counter restarts cleanly after a flush
        applyStimulus("mulhu", 1'b1, 2'b10, 3'b011, 7'h01, 5'h13, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idleStep("mulhu_wait0", 1'b1, 1'b0, 1'b0, 1'b1);
        idleStep("mulhu_wait1", 1'b1, 1'b0, 1'b0, 1'b1);
        idleStep("mulhu_out", 1'b1, 1'b1, 1'b1, 1'b0);

        // reset while holding an unconsumed op
        applyStimulus("rs_sra", 1'b1, 2'b11, 3'b101, 7'h20, 5'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idleStep("rs_hold", 1'b0, 1'b0, 1'b1, 1'b0);
        rst      = 1'b1;
        outReady = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        checkResetValues("rst_out");
        checkOutput("rst_out.in_ready", 5'(inReady), 5'(1'b1));
        idleStep("rst_idle", 1'b1, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
